// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: next-PC select codes, fetch FSM states and the reset NOP.
package fetch_pkg;

  localparam logic [1:0] PC_SEL_JAL  = 2'b00;
  localparam logic [1:0] PC_SEL_JALR = 2'b01;
  localparam logic [1:0] PC_SEL_PC4  = 2'b10;
  localparam logic [1:0] PC_SEL_HOLD = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_HOLD = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection: +4 adder, jump target mux, word alignment and misalignment detect.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] jump_reg_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] raw_pc;

  // NOTE: every always_comb output gets a value before the case so no latch is inferred.
  always_comb begin
    raw_pc = pc;
    unique case (pc_sel)
      PC_SEL_JAL:  raw_pc = jump_target;
      PC_SEL_JALR: raw_pc = jump_reg_target;
      PC_SEL_PC4:  raw_pc = pc + XLEN'(4);
      default:     raw_pc = pc;
    endcase
    // The fetch always proceeds to the aligned address; the low bits only raise the flag.
    next_pc    = {raw_pc[XLEN-1:2], 2'b00};
    misaligned = (raw_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request per instruction and holds
// the returned (pc, inst) pair for decode until it is acknowledged.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'hFFFF_FFFC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] jump_reg_target,
  input  logic            inst_ack,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  output logic            misaligned,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data
);

  localparam logic [XLEN-1:0] BOOT_PC = RESET_PC + XLEN'(4);

  fetch_state_e    state;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  fetch_pc_gen #(.XLEN(XLEN)) u_pc_gen (
    .pc              (pc),
    .pc_sel          (pc_sel),
    .jump_target     (jump_target),
    .jump_reg_target (jump_reg_target),
    .next_pc         (next_pc),
    .misaligned      (next_misaligned)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_BOOT;
      pc             <= RESET_PC;
      inst           <= XLEN'(NOP_INST);
      inst_valid     <= 1'b0;
      misaligned     <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= '0;
    end else begin
      misaligned <= 1'b0;
      unique case (state)
        ST_BOOT: begin
          // RESET_PC is never fetched; the first real fetch is the word after it.
          pc             <= BOOT_PC;
          imem_req_valid <= 1'b1;
          imem_req_addr  <= {BOOT_PC[XLEN-1:2], 2'b00};
          state          <= ST_REQ;
        end
        ST_REQ: begin
          if (imem_req_ready) begin
            imem_req_valid <= 1'b0;
            if (imem_resp_valid) begin
              inst       <= imem_resp_data;
              inst_valid <= 1'b1;
              state      <= ST_HOLD;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            inst       <= imem_resp_data;
            inst_valid <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // A HOLD select is a decode stall: the word stays presented and nothing is fetched.
          if (inst_ack && (pc_sel != PC_SEL_HOLD)) begin
            pc             <= next_pc;
            inst_valid     <= 1'b0;
            misaligned     <= next_misaligned;
            imem_req_valid <= 1'b1;
            imem_req_addr  <= next_pc;
            state          <= ST_REQ;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule
